// File: rtl/md_unit_if.sv
// md_unit_if: bundles the E-stage multiply/divide handshake and HI/LO bus.
//   master : E-stage side (drives start/mdOp/srcA/srcB/rdSel, sees busy/hi/lo/rdData)
//   slave  : md_unit side
//   start  : E-stage instruction is an md op this cycle
//   mdOp   : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   srcA   : forwarded rs value
//   srcB   : forwarded rt value
//   rdSel  : 0 selects LO, 1 selects HI onto rdData
//   busy   : high while a multi-cycle operation is in flight
//   hi/lo  : architectural HI/LO registers
//   rdData : combinational rdSel ? hi : lo
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       mdOp;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             rdSel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdData;

  modport master (
    output start, mdOp, srcA, srcB, rdSel,
    input  busy, hi, lo, rdData
  );

  modport slave (
    input  start, mdOp, srcA, srcB, rdSel,
    output busy, hi, lo, rdData
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers, sitting beside the ALU
// in the E stage. One multi-cycle operation is accepted at a time; busy stays
// high for MULT_CYCLES or DIV_CYCLES cycles, then HI/LO are written.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears all state immediately
//   md    : md_unit_if.slave (start/mdOp/srcA/srcB/rdSel in, busy/hi/lo/rdData out)
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_unit_if.slave    md
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);

  // Architectural and pending-result state
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_res_wr;

  // Next-state values
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_busy_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_res_hi_nxt;
  logic [WIDTH-1:0] w_res_lo_nxt;
  logic             w_res_wr_nxt;

  // Arithmetic datapath
  logic [PW-1:0]    w_prod_s;
  logic [PW-1:0]    w_prod_u;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_b_mag_safe;
  logic [WIDTH-1:0] w_b_u_safe;
  logic [WIDTH-1:0] w_sq_mag;
  logic [WIDTH-1:0] w_sr_mag;
  logic [WIDTH-1:0] w_sq;
  logic [WIDTH-1:0] w_sr;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;

  // Products: sign/zero-extend to 2*WIDTH so one unsigned multiply covers both
  assign w_prod_s = {{WIDTH{md.srcA[WIDTH-1]}}, md.srcA} *
                    {{WIDTH{md.srcB[WIDTH-1]}}, md.srcB};
  assign w_prod_u = {ZERO_W, md.srcA} * {ZERO_W, md.srcB};

  // Signed divide via magnitudes. |most-negative| is representable as an
  // unsigned magnitude, so MIN / -1 naturally wraps back to MIN with rem 0.
  assign w_a_neg      = md.srcA[WIDTH-1];
  assign w_b_neg      = md.srcB[WIDTH-1];
  assign w_b_zero     = (md.srcB == ZERO_W);
  assign w_a_mag      = w_a_neg ? (ZERO_W - md.srcA) : md.srcA;
  assign w_b_mag      = w_b_neg ? (ZERO_W - md.srcB) : md.srcB;
  // Divisor forced to 1 on zero so the datapath never divides by zero;
  // the result is discarded in that case anyway.
  assign w_b_mag_safe = w_b_zero ? ONE_W : w_b_mag;
  assign w_b_u_safe   = w_b_zero ? ONE_W : md.srcB;
  assign w_sq_mag     = w_a_mag / w_b_mag_safe;
  assign w_sr_mag     = w_a_mag % w_b_mag_safe;
  assign w_sq         = (w_a_neg ^ w_b_neg) ? (ZERO_W - w_sq_mag) : w_sq_mag;
  assign w_sr         = w_a_neg ? (ZERO_W - w_sr_mag) : w_sr_mag;
  assign w_uq         = md.srcA / w_b_u_safe;
  assign w_ur         = md.srcA % w_b_u_safe;

  // Next-state and HI/LO update logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_res_hi_nxt = r_res_hi;
    w_res_lo_nxt = r_res_lo;
    w_res_wr_nxt = r_res_wr;

    case (r_state)
      ST_IDLE: begin
        if (md.start) begin
          case (md.mdOp)
            OP_MULT: begin
              w_res_hi_nxt = w_prod_s[PW-1:WIDTH];
              w_res_lo_nxt = w_prod_s[WIDTH-1:0];
              w_res_wr_nxt = 1'b1;
              w_cnt_nxt    = MULT_LAT;
              w_state_nxt  = ST_RUN;
            end
            OP_MULTU: begin
              w_res_hi_nxt = w_prod_u[PW-1:WIDTH];
              w_res_lo_nxt = w_prod_u[WIDTH-1:0];
              w_res_wr_nxt = 1'b1;
              w_cnt_nxt    = MULT_LAT;
              w_state_nxt  = ST_RUN;
            end
            OP_DIV: begin
              w_res_hi_nxt = w_sr;
              w_res_lo_nxt = w_sq;
              w_res_wr_nxt = !w_b_zero;
              w_cnt_nxt    = DIV_LAT;
              w_state_nxt  = ST_RUN;
            end
            OP_DIVU: begin
              w_res_hi_nxt = w_ur;
              w_res_lo_nxt = w_uq;
              w_res_wr_nxt = !w_b_zero;
              w_cnt_nxt    = DIV_LAT;
              w_state_nxt  = ST_RUN;
            end
            OP_MTHI: w_hi_nxt = md.srcA;
            OP_MTLO: w_lo_nxt = md.srcA;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Any start while running is ignored; the counter alone decides completion
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_W'(0);
          if (r_res_wr) begin
            w_hi_nxt = r_res_hi;
            w_lo_nxt = r_res_lo;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == ST_RUN);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= CNT_W'(0);
      r_busy   <= 1'b0;
      r_hi     <= ZERO_W;
      r_lo     <= ZERO_W;
      r_res_hi <= ZERO_W;
      r_res_lo <= ZERO_W;
      r_res_wr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_res_hi <= w_res_hi_nxt;
      r_res_lo <= w_res_lo_nxt;
      r_res_wr <= w_res_wr_nxt;
    end
  end

  assign md.busy   = r_busy;
  assign md.hi     = r_hi;
  assign md.lo     = r_lo;
  assign md.rdData = md.rdSel ? r_hi : r_lo;

endmodule
